os_array_ctrl: RTL and testbench
================================

// Module: os_array_ctrl
// PURPOSE
//  Sequencer for the output-stationary PE array: runs one tile of K-deep accumulation.
//  Feeds operands with a diagonal skew through per-row/per-column read enables, waits
//  for the wavefront to drain, then pulses load_en and issues COL_NUM shift_en beats
//  to move results out of the array. Sits between tile scheduler/operand buffers and the array.
// PARAMETERS
//  ROW_NUM  4   array rows
//  COL_NUM  3   array columns
//  K_WIDTH  16  width of cfg_k (accumulation depth)
//  PE_LAT   1   PE register latency, input to accumulate (drain cycles after feed)
// PORTS
//  clk          in   1                 clock
//  rst_n        in   1                 async reset, active low
//  start        in   1                 tile start request, sampled in IDLE only
//  cfg_k        in   K_WIDTH           accumulation depth K, latched when start accepted
//  busy         out  1                 high from start acceptance to done, inclusive
//  done         out  1                 1-cycle pulse, tile fully shifted out
//  cfg_err      out  1                 1-cycle pulse, start with cfg_k==0 rejected
//  feed_cnt     out  K_WIDTH+1         feed counter; row r reads k=feed_cnt-r, column c reads k=feed_cnt-c
//  row_en       out  ROW_NUM           array v_din_row_en; row operand buffer read enable
//  col_en       out  COL_NUM           column operand buffer read enable
//  load_en      out  1                 array load_en
//  shift_en     out  1                 array shift_en
//  out_rdy      in   1                 downstream accepts a result beat
//  res_vld      out  1                 result beat valid, equal to shift_en
//  res_col_idx  out  $clog2(COL_NUM)+1 column index of the current beat, 0..COL_NUM-1
// BEHAVIOUR
//  Reset: state=IDLE; every output 0; counters 0. An async reset mid-tile aborts it;
//   no done is issued.
//  FSM: IDLE -> FEED -> DRAIN -> LOAD -> SHIFT -> DONE -> IDLE.
//  IDLE: start && cfg_k!=0 -> latch K, feed_cnt=0, busy=1, go to FEED.
//   start && cfg_k==0 -> cfg_err pulse next cycle, stay in IDLE.
//  FEED: F = K+ROW_NUM+COL_NUM-2 cycles. feed_cnt = 0..F-1, +1 per cycle.
//   row_en[r] = (feed_cnt>=r) && (feed_cnt<r+K); col_en[c] = same rule with c.
//   All enables are registered outputs. Trailing cycles have no enable high.
//   Compare arithmetic is K_WIDTH+1 bits, with no overflow for K up to 2^K_WIDTH-1.
//  DRAIN: PE_LAT cycles, all enables 0. With PE_LAT=0, DRAIN is skipped.
//  LOAD: load_en=1 for exactly 1 cycle.
//  SHIFT: shift_en = out_rdy (combinational AND with the SHIFT state).
//   Beat counter advances only on shift_en. Leave SHIFT after COL_NUM beats.
//   out_rdy low stalls with no beat lost. res_col_idx = beat count.
//  DONE: done=1 for 1 cycle, busy=1 in this cycle; next cycle IDLE with busy=0.
//  start while busy: ignored, with no queueing and no error.
//  cfg_k changes after acceptance have no effect on the running tile.
//  Invariant: load_en, shift_en, row_en/col_en are never high in the same cycle.
// CONFIGURATION
//  OS_ARRAY_CTRL_PERF_EN defined:
//   adds outputs perf_tile_cnt[31:0] (+1 per done) and perf_stall_cnt[31:0]
//   (+1 per SHIFT cycle with out_rdy=0). Both saturate at all-ones and reset to 0.
//  OS_ARRAY_CTRL_PERF_EN undefined: these ports and counters do not exist.
//   All other behaviour is identical.
// TESTING  (ROW_NUM=4, COL_NUM=3, PE_LAT=1; start accepted at edge t0)
//  1. cfg_k=2, out_rdy=1.
//     -> FEED t0+1..t0+7 (feed_cnt 0..6); row_en[0] t0+1..2; row_en[3] t0+4..5;
//        col_en[2] t0+3..4; DRAIN t0+8; load_en t0+9; shift_en t0+10..12 (idx 0,1,2);
//        done t0+13; busy low t0+14.
//  2. As 1, but out_rdy=0 during t0+11..t0+13.
//     -> beat 1 at t0+14, beat 2 at t0+15, done t0+16; perf_stall_cnt=3 when the macro is on.
//  3. start with cfg_k=0 -> cfg_err pulse 1 cycle, busy stays 0, no enables.
//  4. start pulsed again at t0+5 of test 1 -> ignored; timeline identical to test 1.
//  5. rst_n low at t0+4 -> all outputs 0 asynchronously; after release, IDLE, no done.
//     A new start with cfg_k=1 completes normally: F=6, done at t0'+12.
//  6. cfg_k=65535 (K_WIDTH=16) -> row_en[3] high feed_cnt 3..65537, done after
//     F+1+1+3+1 cycles; no wrap. With the macro on, 3 back-to-back tiles give perf_tile_cnt=3.

Source files
------------

// File: rtl/os_array_ctrl_if.sv
// Scheduler/result-side bundle for os_array_ctrl: tile command, status, result beats.
interface os_array_ctrl_if #(
   parameter int K_WIDTH = 16,
   parameter int COL_NUM = 3
);
   localparam int IW = $clog2(COL_NUM) + 1;

   logic          start;
   logic [K_WIDTH-1:0] cfg_k;
   logic          busy;
   logic          done;
   logic          cfg_err;
   logic          out_rdy;
   logic          res_vld;
   logic [IW-1:0] res_col_idx;

   modport master (
      output start, cfg_k, out_rdy,
      input  busy, done, cfg_err, res_vld, res_col_idx
   );

   modport slave (
      input  start, cfg_k, out_rdy,
      output busy, done, cfg_err, res_vld, res_col_idx
   );
endinterface

// File: rtl/os_array_ctrl.sv
// os_array_ctrl: output-stationary PE array tile sequencer (feed, drain, load, shift).
// Optional perf counters are built when OS_ARRAY_CTRL_PERF_EN is defined.
module os_array_ctrl #(
   parameter int ROW_NUM = 4,
   parameter int COL_NUM = 3,
   parameter int K_WIDTH = 16,
   parameter int PE_LAT  = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   os_array_ctrl_if.slave     bus,
   output logic [K_WIDTH:0]   feed_cnt,
   output logic [ROW_NUM-1:0] row_en,
   output logic [COL_NUM-1:0] col_en,
   output logic               load_en,
   output logic               shift_en
`ifdef OS_ARRAY_CTRL_PERF_EN
   ,
   output logic [31:0]        perf_tile_cnt,
   output logic [31:0]        perf_stall_cnt
`endif
);
   localparam int CW = K_WIDTH + 1;
   localparam int IW = $clog2(COL_NUM) + 1;
   localparam int DW = $clog2(PE_LAT + 1) + 1;
   localparam logic [CW-1:0] SKEW = CW'(ROW_NUM + COL_NUM - 2);

   typedef enum logic [2:0] {
      IDLE, FEED, DRAIN, LOAD, SHIFT, DONE
   } state_t;

   state_t        state;
   logic [CW-1:0] k_q;
   logic [DW-1:0] drain_cnt;
   logic [IW-1:0] beat;
   logic          busy_q;
   logic          done_q;
   logic          cfg_err_q;
   logic [CW-1:0] feed_last;
   logic [CW-1:0] feed_nxt;
   logic [CW-1:0] k_in;

   // Diagonal skew: lane i is live while i <= fc < i+K.
   function automatic logic [ROW_NUM-1:0] row_mask(
      input logic [CW-1:0] fc,
      input logic [CW-1:0] k
   );
      row_mask = '0;
      for (int r = 0; r < ROW_NUM; r++)
         row_mask[r] = (fc >= CW'(r)) && (fc < CW'(r) + k);
   endfunction

   function automatic logic [COL_NUM-1:0] col_mask(
      input logic [CW-1:0] fc,
      input logic [CW-1:0] k
   );
      col_mask = '0;
      for (int c = 0; c < COL_NUM; c++)
         col_mask[c] = (fc >= CW'(c)) && (fc < CW'(c) + k);
   endfunction

   assign k_in      = {1'b0, bus.cfg_k};
   assign feed_last = k_q + SKEW - CW'(1);
   assign feed_nxt  = feed_cnt + CW'(1);

   assign shift_en        = (state == SHIFT) && bus.out_rdy;
   assign bus.res_vld     = shift_en;
   assign bus.res_col_idx = beat;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.cfg_err     = cfg_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         k_q       <= '0;
         feed_cnt  <= '0;
         row_en    <= '0;
         col_en    <= '0;
         load_en   <= 1'b0;
         drain_cnt <= '0;
         beat      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         cfg_err_q <= 1'b0;
         load_en   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  if (bus.cfg_k == '0) begin
                     cfg_err_q <= 1'b1;
                  end else begin
                     k_q      <= k_in;
                     feed_cnt <= '0;
                     busy_q   <= 1'b1;
                     row_en   <= row_mask('0, k_in);
                     col_en   <= col_mask('0, k_in);
                     state    <= FEED;
                  end
               end
            end
            FEED: begin
               if (feed_cnt == feed_last) begin
                  feed_cnt  <= '0;
                  row_en    <= '0;
                  col_en    <= '0;
                  drain_cnt <= '0;
                  if (PE_LAT == 0) begin
                     load_en <= 1'b1;
                     state   <= LOAD;
                  end else begin
                     state <= DRAIN;
                  end
               end else begin
                  feed_cnt <= feed_nxt;
                  row_en   <= row_mask(feed_nxt, k_q);
                  col_en   <= col_mask(feed_nxt, k_q);
               end
            end
            DRAIN: begin
               if (drain_cnt == DW'(PE_LAT - 1)) begin
                  load_en <= 1'b1;
                  state   <= LOAD;
               end else begin
                  drain_cnt <= drain_cnt + DW'(1);
               end
            end
            LOAD: begin
               beat  <= '0;
               state <= SHIFT;
            end
            SHIFT: begin
               if (bus.out_rdy) begin
                  if (beat == IW'(COL_NUM - 1)) begin
                     beat   <= '0;
                     done_q <= 1'b1;
                     state  <= DONE;
                  end else begin
                     beat <= beat + IW'(1);
                  end
               end
            end
            DONE: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef OS_ARRAY_CTRL_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_tile_cnt  <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (state == DONE && perf_tile_cnt != '1)
            perf_tile_cnt <= perf_tile_cnt + 32'd1;
         if (state == SHIFT && !bus.out_rdy && perf_stall_cnt != '1)
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_os_array_ctrl.sv
// Self-checking bench for os_array_ctrl: cycle timeline checks plus a result-beat scoreboard.
module tb_os_array_ctrl;
   localparam int ROW_NUM = 4;
   localparam int COL_NUM = 3;
   localparam int K_WIDTH = 16;
   localparam int PE_LAT  = 1;
   localparam int IW      = $clog2(COL_NUM) + 1;

   typedef struct {
      int idx;
      int n;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [K_WIDTH:0]   feed_cnt;
   logic [ROW_NUM-1:0] row_en;
   logic [COL_NUM-1:0] col_en;
   logic               load_en;
   logic               shift_en;
`ifdef OS_ARRAY_CTRL_PERF_EN
   logic [31:0] perf_tile_cnt;
   logic [31:0] perf_stall_cnt;
`endif

   int n_pass = 0;
   int n_total = 0;
   beat_t sb[$];

   os_array_ctrl_if #(.K_WIDTH(K_WIDTH), .COL_NUM(COL_NUM)) bus ();

   os_array_ctrl #(
      .ROW_NUM(ROW_NUM), .COL_NUM(COL_NUM),
      .K_WIDTH(K_WIDTH), .PE_LAT(PE_LAT)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus),
      .feed_cnt(feed_cnt),
      .row_en(row_en),
      .col_en(col_en),
      .load_en(load_en),
      .shift_en(shift_en)
`ifdef OS_ARRAY_CTRL_PERF_EN
      ,
      .perf_tile_cnt(perf_tile_cnt),
      .perf_stall_cnt(perf_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Runs one tile; cycle n is the sample after edge t0+n-1 (spec index t0+n).
   task automatic run_tile(input int k, input int st_lo, input int st_hi,
                           input int restart, input string tag);
      int f, s, m, done_n;
      beat_t b;
      logic [ROW_NUM-1:0] er;
      logic [COL_NUM-1:0] ec;
      logic [K_WIDTH:0] efc;
      logic [5+ROW_NUM+COL_NUM+K_WIDTH:0] obs, exp_v;
      f = k + ROW_NUM + COL_NUM - 2;
      s = f + PE_LAT + 2;
      m = s;
      for (int i = 0; i < COL_NUM; i++) begin
         while (m >= st_lo && m <= st_hi) m++;
         sb.push_back('{i, m});
         m++;
      end
      done_n = m;
      @(negedge clk);
      bus.start = 1'b1;
      bus.cfg_k = k[K_WIDTH-1:0];
      bus.out_rdy = 1'b1;
      @(posedge clk);
      for (int n = 1; n <= done_n + 1; n++) begin
         @(negedge clk);
         bus.start = (n == restart);
         bus.cfg_k = K_WIDTH'($urandom);
         bus.out_rdy = !(n >= st_lo && n <= st_hi);
         #1;
         er = '0;
         ec = '0;
         efc = '0;
         if (n <= f) begin
            efc = (K_WIDTH+1)'(n - 1);
            for (int r = 0; r < ROW_NUM; r++)
               er[r] = (n - 1 >= r) && (n - 1 < r + k);
            for (int c = 0; c < COL_NUM; c++)
               ec[c] = (n - 1 >= c) && (n - 1 < c + k);
         end
         exp_v = {n <= done_n, n == done_n, 1'b0,
                  n == f + PE_LAT + 1,
                  n >= s && n < done_n && bus.out_rdy,
                  er, ec, efc};
         obs = {bus.busy, bus.done, bus.cfg_err, load_en,
                shift_en, row_en, col_en, feed_cnt};
         n_total++;
         if (obs !== exp_v)
            $display("FAIL %s cyc%0d {busy,done,err,load,shift,row,col,fc} got %h want %h",
                     tag, n, obs, exp_v);
         else
            n_pass++;
         if (bus.res_vld) begin
            n_total++;
            if (sb.size() == 0) begin
               $display("FAIL %s beat cyc%0d unexpected idx %0d", tag, n, bus.res_col_idx);
            end else begin
               b = sb.pop_front();
               if (int'(bus.res_col_idx) !== b.idx || n != b.n)
                  $display("FAIL %s beat got idx %0d @%0d want idx %0d @%0d",
                           tag, bus.res_col_idx, n, b.idx, b.n);
               else
                  n_pass++;
            end
         end
      end
      n_total++;
      if (sb.size() != 0) begin
         $display("FAIL %s beats_left got %0d want 0", tag, sb.size());
         sb.delete();
      end else begin
         n_pass++;
      end
   endtask

   task automatic test_reset();
      #1;
      n_total++;
      if ({bus.busy, bus.done, bus.cfg_err, bus.res_vld, load_en, shift_en,
           row_en, col_en, feed_cnt} !== '0)
         $display("FAIL reset outputs got nonzero busy=%b en=%b/%b fc=%0d want 0",
                  bus.busy, row_en, col_en, feed_cnt);
      else
         n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      run_tile(2, -1, -1, -1, "basic");
   endtask

   task automatic test_stall();
`ifdef OS_ARRAY_CTRL_PERF_EN
      logic [31:0] before;
      before = perf_stall_cnt;
`endif
      run_tile(2, 11, 13, -1, "stall");
`ifdef OS_ARRAY_CTRL_PERF_EN
      n_total++;
      if (perf_stall_cnt !== before + 32'd3)
         $display("FAIL perf_stall got %0d want %0d", perf_stall_cnt, before + 3);
      else
         n_pass++;
`endif
   endtask

   task automatic test_cfg_err();
      @(negedge clk);
      bus.start = 1'b1;
      bus.cfg_k = '0;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      n_total++;
      if ({bus.cfg_err, bus.busy, row_en, col_en} !== {2'b10, {(ROW_NUM+COL_NUM){1'b0}}})
         $display("FAIL cfg_err pulse got err=%b busy=%b en=%b/%b want 1,0,0,0",
                  bus.cfg_err, bus.busy, row_en, col_en);
      else
         n_pass++;
      @(negedge clk);
      #1;
      n_total++;
      if ({bus.cfg_err, bus.busy} !== 2'b00)
         $display("FAIL cfg_err width got err=%b busy=%b want 0,0", bus.cfg_err, bus.busy);
      else
         n_pass++;
   endtask

   task automatic test_start_ignored();
      run_tile(2, -1, -1, 5, "restart");
   endtask

   task automatic test_reset_abort();
      int seen_done;
      @(negedge clk);
      bus.start = 1'b1;
      bus.cfg_k = 16'd2;
      bus.out_rdy = 1'b1;
      @(posedge clk);
      for (int n = 1; n <= 4; n++) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      #1;
      rst_n = 1'b0;
      #1;
      n_total++;
      if ({bus.busy, bus.done, bus.res_vld, load_en, shift_en, row_en, col_en, feed_cnt} !== '0)
         $display("FAIL abort outputs got busy=%b en=%b/%b fc=%0d want 0",
                  bus.busy, row_en, col_en, feed_cnt);
      else
         n_pass++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen_done = 0;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         #1;
         if (bus.done || bus.busy) seen_done++;
      end
      n_total++;
      if (seen_done != 0)
         $display("FAIL abort_idle got %0d busy/done cycles want 0", seen_done);
      else
         n_pass++;
      run_tile(1, -1, -1, -1, "after_abort");
   endtask

   task automatic test_back_to_back();
`ifdef OS_ARRAY_CTRL_PERF_EN
      logic [31:0] before;
      before = perf_tile_cnt;
`endif
      run_tile(1, -1, -1, -1, "b2b0");
      run_tile(3, 12, 12, -1, "b2b1");
      run_tile(5, -1, -1, -1, "b2b2");
`ifdef OS_ARRAY_CTRL_PERF_EN
      n_total++;
      if (perf_tile_cnt !== before + 32'd3)
         $display("FAIL perf_tile got %0d want %0d", perf_tile_cnt, before + 3);
      else
         n_pass++;
`endif
   endtask

   task automatic test_long_k();
      run_tile(65535, -1, -1, -1, "k_max");
   endtask

   initial begin
      bus.start = 1'b0;
      bus.cfg_k = '0;
      bus.out_rdy = 1'b0;
      test_reset();
      test_basic();
      test_stall();
      test_cfg_err();
      test_start_ignored();
      test_reset_abort();
      test_back_to_back();
      test_long_k();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
